// File: rtl/adder_result_fifo.sv
// adder_result_fifo: registered, first-word-fall-through result buffer for the
// simpleAdder. It stores {overflow, carry, sum} triples in order and keeps a
// sticky overflow flag.
// Optional feature: define ADDER_RESULT_STATS_EN to build the saturating
// ovf_count / carry_count statistics counters. Without it both ports read 0.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. Valid never depends on ready. in_ready depends only on count, and out_valid
// depends only on count, so out_ready has no combinational path to in_ready.
module adder_result_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_sum,
  input  logic                     in_carry,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_sum,
  output logic                     out_carry,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic [CNT_W-1:0]         ovf_count,
  output logic [CNT_W-1:0]         carry_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Each entry is {overflow, carry, sum}: N + 2 bits, stored exactly.
  logic [N+1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_sticky;

  logic             w_push;
  logic             w_pop;
  logic [N+1:0]     w_head;

  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Head of queue is read straight from storage (first-word-fall-through).
  assign w_head       = r_mem[r_rd_ptr];
  assign out_sum      = w_head[N-1:0];
  assign out_carry    = w_head[N];
  assign out_overflow = w_head[N+1];
  assign count        = r_count;
  assign sticky_ovf   = r_sticky;

  // Storage write and write pointer; storage is zeroed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {in_overflow, in_carry, in_sum};
      r_wr_ptr        <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every pop and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a pushed overflow wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_push && in_overflow) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

`ifdef ADDER_RESULT_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_ovf_count;
  logic [CNT_W-1:0] r_carry_count;

  // Saturating event counters; only rst_n clears them, clr_sticky does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count   <= '0;
      r_carry_count <= '0;
    end else begin
      if (w_push && in_overflow && (r_ovf_count != CNT_MAX))
        r_ovf_count <= r_ovf_count + 1'b1;
      if (w_push && in_carry && (r_carry_count != CNT_MAX))
        r_carry_count <= r_carry_count + 1'b1;
    end
  end

  assign ovf_count   = r_ovf_count;
  assign carry_count = r_carry_count;
`else
  assign ovf_count   = '0;
  assign carry_count = '0;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// tb_adder_result_fifo: directed table plus hand-written sequences for
// adder_result_fifo (DEPTH = 4, N = 32).
module tb_adder_result_fifo;

`ifdef ADDER_RESULT_STATS_EN
  localparam int TB_CNT_W    = 2;
  localparam int EXP_CARRY_C = 3;  // 5 carry pushes saturate a 2-bit counter
  localparam int EXP_OVF_C   = 2;
`else
  localparam int TB_CNT_W    = 16;
  localparam int EXP_CARRY_C = 0;
  localparam int EXP_OVF_C   = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                in_valid, in_ready, in_carry, in_overflow;
  logic [31:0]         in_sum;
  logic                out_valid, out_ready, out_carry, out_overflow;
  logic [31:0]         out_sum;
  logic [2:0]          count;
  logic                sticky_ovf, clr_sticky;
  logic [TB_CNT_W-1:0] ovf_count, carry_count;

  adder_result_fifo #(.N(32), .DEPTH(4), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_overflow(out_overflow),
    .count(count), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
    .ovf_count(ovf_count), .carry_count(carry_count)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];   // {overflow, carry, sum}
  int   m_cnt;
  logic m_st;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic vld, input logic [31:0] sum, input logic c,
                       input logic o, input logic rdy, input logic clr);
    in_valid    = vld;
    in_sum      = sum;
    in_carry    = c;
    in_overflow = o;
    out_ready   = rdy;
    clr_sticky  = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle against the reference queue model: checks head and in_ready
  // before the edge, count/out_valid/sticky after it.
  task automatic model_step(input logic vld, input logic [31:0] sum, input logic c,
                            input logic o, input logic rdy, input logic clr);
    logic push, pop;
    drive(vld, sum, c, o, rdy, clr);
    chk("pre_in_ready", in_ready, (m_cnt != 4));
    if (m_cnt != 0) chk("head_data", {out_overflow, out_carry, out_sum}, exp_q[0]);
    push = vld && (m_cnt != 4);
    pop  = rdy && (m_cnt != 0);
    tick();
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back({o, c, sum});
    m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
    if (push && o) m_st = 1'b1;
    else if (clr)  m_st = 1'b0;
    chk("count", count, m_cnt);
    chk("out_valid", out_valid, (m_cnt != 0));
    chk("sticky", sticky_ovf, m_st);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        vld;
    logic [31:0] sum;
    logic        c;
    logic        o;
    logic        rdy;
    logic        clr;
    logic [2:0]  e_cnt;
    logic        e_ov;
    logic [31:0] e_sum;
    logic        e_c;
    logic        e_o;
    logic        e_ir;
    logic        e_st;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  initial begin
    // vld  sum           c  o  rdy clr | cnt ov  head          c  o  ir st
    vt[0]  = '{1, 32'h5FFFFFFE, 1, 1, 0, 0, 1, 1, 32'h5FFFFFFE, 1, 1, 1, 1};
    vt[1]  = '{0, 32'h0,        0, 0, 0, 1, 1, 1, 32'h5FFFFFFE, 1, 1, 1, 0};
    vt[2]  = '{0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0};
    vt[3]  = '{1, 32'd1,        0, 0, 0, 0, 1, 1, 32'd1,        0, 0, 1, 0};
    vt[4]  = '{1, 32'd2,        1, 0, 0, 0, 2, 1, 32'd1,        0, 0, 1, 0};
    vt[5]  = '{1, 32'd3,        0, 0, 0, 0, 3, 1, 32'd1,        0, 0, 1, 0};
    vt[6]  = '{1, 32'd4,        0, 0, 0, 0, 4, 1, 32'd1,        0, 0, 0, 0};
    vt[7]  = '{1, 32'd5,        0, 0, 0, 0, 4, 1, 32'd1,        0, 0, 0, 0};
    vt[8]  = '{0, 32'h0,        0, 0, 1, 0, 3, 1, 32'd2,        1, 0, 1, 0};
    vt[9]  = '{0, 32'h0,        0, 0, 1, 0, 2, 1, 32'd3,        0, 0, 1, 0};
    vt[10] = '{0, 32'h0,        0, 0, 1, 0, 1, 1, 32'd4,        0, 0, 1, 0};
    vt[11] = '{0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0};
    vt[12] = '{0, 32'h0,        0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 1, 0};
    vt[13] = '{1, 32'd6,        0, 0, 1, 0, 1, 1, 32'd6,        0, 0, 1, 0};
    vt[14] = '{1, 32'd7,        0, 0, 1, 0, 1, 1, 32'd7,        0, 0, 1, 0};

    drive(0, 32'h0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // ---- reset values ----
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_ovf", out_overflow, 0);
    chk("rst_count", count, 0);
    chk("rst_sticky", sticky_ovf, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_carry_count", carry_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].vld, vt[i].sum, vt[i].c, vt[i].o, vt[i].rdy, vt[i].clr);
      tick();
      chk($sformatf("v%0d_count", i), count, vt[i].e_cnt);
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ir);
      chk($sformatf("v%0d_sticky", i), sticky_ovf, vt[i].e_st);
      if (vt[i].e_ov) begin
        chk($sformatf("v%0d_out_sum", i), out_sum, vt[i].e_sum);
        chk($sformatf("v%0d_out_carry", i), out_carry, vt[i].e_c);
        chk($sformatf("v%0d_out_ovf", i), out_overflow, vt[i].e_o);
      end
    end

    // ---- fill to full, then push+pop every cycle across pointer wrap ----
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b0, 32'd7});
    m_cnt = 1;
    m_st  = 1'b0;
    for (int k = 0; k < 4; k++)
      model_step(1, 32'd100 + k, k[0], 0, 0, 0);
    for (int k = 0; k < 10; k++)
      model_step(1, 32'd200 + k, k[1], 0, 1, 0);

    // ---- sticky priority: set wins over same-cycle clear ----
    model_step(1, 32'hDEAD0001, 0, 1, 1, 1);
    chk("sticky_set_wins", sticky_ovf, 1);
    model_step(0, 32'h0, 0, 0, 0, 1);
    chk("sticky_clear", sticky_ovf, 0);

    // ---- asynchronous reset mid-cycle with 2 entries held ----
    model_step(1, 32'hBEEF0002, 0, 1, 1, 0);
    while (m_cnt > 2) model_step(0, 32'h0, 0, 0, 1, 0);
    chk("pre_reset_count", count, 2);
    drive(0, 32'h0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_sticky", sticky_ovf, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    m_cnt = 0;
    m_st  = 1'b0;

    // ---- statistics counters (zero when the feature is not built) ----
    for (int k = 0; k < 5; k++)
      model_step(1, 32'h1000 + k, 1, 0, 1, 0);
    chk("carry_count", carry_count, EXP_CARRY_C);
    for (int k = 0; k < 2; k++)
      model_step(1, 32'h2000 + k, 0, 1, 1, 0);
    chk("ovf_count", ovf_count, EXP_OVF_C);
    model_step(0, 32'h0, 0, 0, 1, 1);
    chk("ovf_count_after_clr", ovf_count, EXP_OVF_C);
    chk("carry_count_after_clr", carry_count, EXP_CARRY_C);

    // ---- final report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
